// File: rtl/food_ctrl.sv
// food_ctrl: places food on the snake grid from a free-running LFSR, checks
// each candidate cell against the snake-body occupancy logic, and pulses
// get_food when the snake head lands on the food.
module food_ctrl #(
   parameter int          GRID_W    = 40,
   parameter int          GRID_H    = 30,
   parameter int          XW        = 6,
   parameter int          YW        = 5,
   parameter logic [15:0] SEED      = 16'hACE1,
   parameter int          MAX_TRIES = 255
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [1:0]    game_state,
   input  logic          head_valid,
   input  logic [XW-1:0] head_x,
   input  logic [YW-1:0] head_y,
   output logic          chk_req,
   output logic [XW-1:0] chk_x,
   output logic [YW-1:0] chk_y,
   input  logic          occ_valid,
   input  logic          occ_hit,
   output logic [XW-1:0] food_x,
   output logic [YW-1:0] food_y,
   output logic          food_valid,
   output logic          get_food,
   output logic          board_full
);

   localparam logic [15:0] SEED_EFF = (SEED == 16'h0000) ? 16'hACE1 : SEED;
   localparam int          TW       = $clog2(MAX_TRIES + 1);

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_DRAW   = 3'd1,
      ST_CHECK  = 3'd2,
      ST_PLACED = 3'd3,
      ST_FULL   = 3'd4
   } state_t;

   state_t        state_q, state_d;
   logic [15:0]   lfsr_q, lfsr_d;
   logic [TW-1:0] try_q, try_d;
   logic          chk_req_q, chk_req_d;
   logic [XW-1:0] chk_x_q, chk_x_d;
   logic [YW-1:0] chk_y_q, chk_y_d;
   logic [XW-1:0] food_x_q, food_x_d;
   logic [YW-1:0] food_y_q, food_y_d;
   logic          food_valid_q, food_valid_d;
   logic          get_food_q, get_food_d;
   logic          board_full_q, board_full_d;

   logic [XW-1:0] cand_x;
   logic [YW-1:0] cand_y;
   logic          cand_in_range;
   logic          lfsr_fb;

   // Candidate cell is taken straight from the current LFSR value.
   always_comb begin
      cand_x        = lfsr_q[XW-1:0];
      cand_y        = lfsr_q[8+YW-1:8];
      cand_in_range = ({1'b0, cand_x} < (XW+1)'(GRID_W)) &&
                      ({1'b0, cand_y} < (YW+1)'(GRID_H));
      lfsr_fb       = lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5];
   end

   // Next-state and registered-output logic; not playing overrides everything.
   always_comb begin
      state_d      = state_q;
      lfsr_d       = {lfsr_fb, lfsr_q[15:1]};
      try_d        = try_q;
      chk_req_d    = 1'b0;
      chk_x_d      = chk_x_q;
      chk_y_d      = chk_y_q;
      food_x_d     = food_x_q;
      food_y_d     = food_y_q;
      food_valid_d = food_valid_q;
      get_food_d   = 1'b0;
      board_full_d = board_full_q;
      if (game_state != 2'b00) begin
         state_d      = ST_IDLE;
         try_d        = '0;
         food_valid_d = 1'b0;
         board_full_d = 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               try_d   = '0;
               state_d = ST_DRAW;
            end
            ST_DRAW: begin
               if (cand_in_range) begin
                  chk_x_d   = cand_x;
                  chk_y_d   = cand_y;
                  chk_req_d = 1'b1;
                  state_d   = ST_CHECK;
               end else begin
                  state_d = ST_DRAW;
               end
            end
            ST_CHECK: begin
               if (occ_valid) begin
                  if (!occ_hit) begin
                     food_x_d     = chk_x_q;
                     food_y_d     = chk_y_q;
                     food_valid_d = 1'b1;
                     try_d        = '0;
                     state_d      = ST_PLACED;
                  end else if (try_q == TW'(MAX_TRIES - 1)) begin
                     try_d        = try_q + TW'(1);
                     board_full_d = 1'b1;
                     food_valid_d = 1'b0;
                     state_d      = ST_FULL;
                  end else begin
                     try_d   = try_q + TW'(1);
                     state_d = ST_DRAW;
                  end
               end else begin
                  state_d = ST_CHECK;
               end
            end
            ST_PLACED: begin
               if (head_valid && (head_x == food_x_q) && (head_y == food_y_q)) begin
                  get_food_d   = 1'b1;
                  food_valid_d = 1'b0;
                  state_d      = ST_DRAW;
               end else begin
                  state_d = ST_PLACED;
               end
            end
            ST_FULL: begin
               board_full_d = 1'b1;
               food_valid_d = 1'b0;
               state_d      = ST_FULL;
            end
            default: begin
               state_d = ST_IDLE;
            end
         endcase
      end
   end

   // State, LFSR and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         lfsr_q       <= SEED_EFF;
         try_q        <= '0;
         chk_req_q    <= 1'b0;
         chk_x_q      <= '0;
         chk_y_q      <= '0;
         food_x_q     <= '0;
         food_y_q     <= '0;
         food_valid_q <= 1'b0;
         get_food_q   <= 1'b0;
         board_full_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         lfsr_q       <= lfsr_d;
         try_q        <= try_d;
         chk_req_q    <= chk_req_d;
         chk_x_q      <= chk_x_d;
         chk_y_q      <= chk_y_d;
         food_x_q     <= food_x_d;
         food_y_q     <= food_y_d;
         food_valid_q <= food_valid_d;
         get_food_q   <= get_food_d;
         board_full_q <= board_full_d;
      end
   end

   assign chk_req    = chk_req_q;
   assign chk_x      = chk_x_q;
   assign chk_y      = chk_y_q;
   assign food_x     = food_x_q;
   assign food_y     = food_y_q;
   assign food_valid = food_valid_q;
   assign get_food   = get_food_q;
   assign board_full = board_full_q;

endmodule
